cub_sqrt_arbiter: RTL and testbench

//  Shares one cub_sqrt unit (8-bit integer cube root, start/busy handshake) between NREQ requesters.

---
 rtl/cub_sqrt_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cub_sqrt_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cub_sqrt_arbiter.sv
// Round-robin arbiter that shares one cub_sqrt unit between NREQ requesters.
// Sequences the start/busy handshake, guards it with a watchdog, and returns id-tagged results.
//
// state     | meaning
// IDLE      | waiting for a request, grant issued combinationally
// ISSUE     | cs_start_o held until the unit reports busy
// WAIT_DONE | unit computing, waiting for busy to fall
// RECOVER   | unit hung, cs_rst_o pulsed for two cycles
// RESP      | response presented until the consumer accepts it
module cub_sqrt_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_x_bi,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [7:0]        rsp_y_bo,
    output logic              rsp_err_o,
    output logic              cs_rst_o,
    output logic              cs_start_o,
    output logic [7:0]        cs_x_bo,
    input  logic              cs_busy_i,
    input  logic [7:0]        cs_y_bi
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RECOVER,
        RESP
    } state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  last_grant;
    logic [WDW-1:0]  wd_cnt;
    logic            rec_cnt;

    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic [7:0]      grant_x;
    logic [NREQ-1:0] grant_oh;
    int              idx;

    logic            issue_ack;
    logic            done_hit;
    logic            wd_trip;
    logic            rec_last;

    // Rotating scan starting just after the previous winner.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        grant_x     = '0;
        grant_oh    = '0;
        idx         = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_grant) + i) % NREQ;
            if (!grant_found && req_valid_i[idx]) begin
                grant_found   = 1'b1;
                grant_id      = IDW'(idx);
                grant_x       = req_x_bi[8*idx +: 8];
                grant_oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        issue_ack = 1'b0;
        done_hit  = 1'b0;
        wd_trip   = 1'b0;
        rec_last  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (cs_busy_i) begin
                    issue_ack = 1'b1;
                    state_nxt = WAIT_DONE;
                end else if (wd_cnt == '0) begin
                    wd_trip   = 1'b1;
                    state_nxt = RECOVER;
                end
            end
            WAIT_DONE: begin
                if (!cs_busy_i) begin
                    done_hit  = 1'b1;
                    state_nxt = RESP;
                end else if (wd_cnt == '0) begin
                    wd_trip   = 1'b1;
                    state_nxt = RECOVER;
                end
            end
            RECOVER: begin
                if (rec_cnt) begin
                    rec_last  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready_o = (state == IDLE) ? grant_oh : '0;
    assign rsp_valid_o = (state == RESP);

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_grant <= IDW'(NREQ - 1);
            wd_cnt     <= '0;
            rec_cnt    <= 1'b0;
            rsp_id_o   <= '0;
            rsp_y_bo   <= '0;
            rsp_err_o  <= 1'b0;
            cs_rst_o   <= 1'b1;
            cs_start_o <= 1'b0;
            cs_x_bo    <= '0;
        end else begin
            // Unit reset is high on the trip edge and through the first recover cycle.
            cs_rst_o <= wd_trip || (state == RECOVER && !rec_cnt);

            if (wd_trip)                rec_cnt <= 1'b0;
            else if (state == RECOVER)  rec_cnt <= 1'b1;

            if (state == IDLE && grant_found) begin
                cs_x_bo    <= grant_x;
                rsp_id_o   <= grant_id;
                last_grant <= grant_id;
                wd_cnt     <= WDW'(TIMEOUT - 1);
                cs_start_o <= 1'b1;
            end else if ((state == ISSUE || state == WAIT_DONE) && wd_cnt != '0) begin
                wd_cnt <= wd_cnt - 1'b1;
            end

            if (issue_ack || wd_trip) cs_start_o <= 1'b0;

            if (done_hit) begin
                rsp_y_bo  <= cs_y_bi;
                rsp_err_o <= 1'b0;
            end else if (rec_last) begin
                rsp_y_bo  <= '0;
                rsp_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cub_sqrt_arbiter.sv
// Bench for cub_sqrt_arbiter: behavioural cub_sqrt unit, directed vector table and
// hand-written sequences for arbitration order, backpressure, watchdog and mid-op reset.
module tb_cub_sqrt_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_x = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_y;
    logic              rsp_err;
    logic              cs_rst;
    logic              cs_start;
    logic [7:0]        cs_x;
    logic              cs_busy = 1'b0;
    logic [7:0]        cs_y = '0;

    cub_sqrt_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid),
        .req_x_bi    (req_x),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_y_bo    (rsp_y),
        .rsp_err_o   (rsp_err),
        .cs_rst_o    (cs_rst),
        .cs_start_o  (cs_start),
        .cs_x_bo     (cs_x),
        .cs_busy_i   (cs_busy),
        .cs_y_bi     (cs_y)
    );

    always #5 clk = ~clk;

    // Behavioural cube-root unit: busy for three cycles, or forever when stuck.
    logic       stuck = 1'b0;
    logic [7:0] unit_x = '0;
    logic [1:0] unit_cnt = '0;

    function automatic logic [7:0] cbrt8(input logic [7:0] v);
        int r = 0;
        for (int i = 1; i <= 6; i++) if (i * i * i <= int'(v)) r = i;
        return 8'(r);
    endfunction

    always @(posedge clk) begin
        if (cs_rst === 1'b1) begin
            cs_busy  <= 1'b0;
            cs_y     <= '0;
            unit_cnt <= '0;
        end else if (cs_busy) begin
            if (!stuck) begin
                if (unit_cnt == 0) begin
                    cs_busy <= 1'b0;
                    cs_y    <= cbrt8(unit_x);
                end else begin
                    unit_cnt <= unit_cnt - 1'b1;
                end
            end
        end else if (cs_start === 1'b1) begin
            cs_busy  <= 1'b1;
            unit_x   <= cs_x;
            unit_cnt <= 2'd2;
        end
    end

    typedef struct {
        int id;
        int y;
        int err;
    } rsp_t;

    typedef struct {
        int         k;
        logic [7:0] x;
        logic [7:0] y;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_start = 0;
    int   rst_hi_n = 0;
    int   start_rise_cyc = 0;
    int   rst_rise_cyc = 0;
    logic start_prev = 1'b0;
    logic rst_prev = 1'b0;
    logic [NREQ-1:0] sticky = '0;
    logic [NREQ-1:0] rdy_seen;
    rsp_t rsp_q[$];
    int   grant_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample at negedge, advance past the edge, retire granted requests.
    task automatic tick();
        @(negedge clk);
        rdy_seen = req_ready;
        if (rst_n) begin
            if (req_ready != '0) begin
                chk("ready_onehot", $countones(req_ready), 1);
                chk("ready_without_valid", int'(req_ready & ~req_valid), 0);
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) grant_q.push_back(k);
            end
            if (rsp_valid && rsp_ready) rsp_q.push_back('{int'(rsp_id), int'(rsp_y), int'(rsp_err)});
            if (cs_start && !start_prev) begin
                n_start++;
                start_rise_cyc = cyc;
            end
        end
        if (cs_rst) rst_hi_n++;
        if (cs_rst && !rst_prev) rst_rise_cyc = cyc;
        start_prev = cs_start;
        rst_prev   = cs_rst;
        @(posedge clk);
        #1;
        cyc++;
        req_valid = req_valid & ~(rdy_seen & ~sticky);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        sticky    = '0;
        stuck     = 1'b0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        rsp_q.delete();
        grant_q.delete();
        n_start  = 0;
        rst_hi_n = 0;
    endtask

    task automatic run_until_rsp(input int n, input int bound);
        int b = 0;
        while (rsp_q.size() < n && b < bound) begin
            tick();
            b++;
        end
        chk("rsp_arrival", rsp_q.size(), n);
    endtask

    task automatic txn(input int k, input logic [7:0] x, input logic [7:0] ey);
        int n0 = rsp_q.size();
        int g0 = grant_q.size();
        int s0 = n_start;
        req_x[8*k +: 8] = x;
        req_valid[k]    = 1'b1;
        run_until_rsp(n0 + 1, 200);
        if (rsp_q.size() > n0) begin
            chk($sformatf("txn_id x=%0d", x), rsp_q[n0].id, k);
            chk($sformatf("txn_y x=%0d", x), rsp_q[n0].y, int'(ey));
            chk($sformatf("txn_err x=%0d", x), rsp_q[n0].err, 0);
        end
        chk($sformatf("txn_grants x=%0d", x), grant_q.size() - g0, 1);
        chk($sformatf("txn_starts x=%0d", x), n_start - s0, 1);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{0,  8'd27,  8'd3};
        vecs[1]  = '{1,  8'd0,   8'd0};
        vecs[2]  = '{2,  8'd1,   8'd1};
        vecs[3]  = '{3,  8'd7,   8'd1};
        vecs[4]  = '{0,  8'd8,   8'd2};
        vecs[5]  = '{1,  8'd63,  8'd3};
        vecs[6]  = '{2,  8'd64,  8'd4};
        vecs[7]  = '{3,  8'd124, 8'd4};
        vecs[8]  = '{0,  8'd125, 8'd5};
        vecs[9]  = '{1,  8'd215, 8'd5};
        vecs[10] = '{2,  8'd216, 8'd6};
        vecs[11] = '{3,  8'd255, 8'd6};

        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_ready", int'(req_ready), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_id", int'(rsp_id), 0);
        chk("reset_rsp_y", int'(rsp_y), 0);
        chk("reset_rsp_err", int'(rsp_err), 0);
        chk("reset_cs_start", int'(cs_start), 0);
        chk("reset_cs_x", int'(cs_x), 0);
        chk("reset_cs_rst", int'(cs_rst), 1);
        do_reset();

        // Single requests from each port, covering root boundaries.
        for (int i = 0; i < 12; i++) txn(vecs[i].k, vecs[i].x, vecs[i].y);

        // Four simultaneous requests drain in id order.
        do_reset();
        req_x     = {8'd216, 8'd125, 8'd64, 8'd8};
        req_valid = 4'b1111;
        run_until_rsp(4, 400);
        for (int i = 0; i < 4; i++) begin
            if (i < rsp_q.size()) begin
                chk($sformatf("simul_id[%0d]", i), rsp_q[i].id, i);
                chk($sformatf("simul_y[%0d]", i), rsp_q[i].y, (i == 0) ? 2 : (i == 1) ? 4 : (i == 2) ? 5 : 6);
            end
        end

        // Persistent requesters 1 and 3 alternate; a late req0 wins after a req3 grant.
        do_reset();
        req_x     = {8'd0, 8'd0, 8'd1, 8'd0};
        sticky    = 4'b1010;
        req_valid = 4'b1010;
        for (int b = 0; b < 400 && grant_q.size() < 4; b++) tick();
        req_x[7:0]   = 8'd27;
        req_valid[0] = 1'b1;
        for (int b = 0; b < 200 && grant_q.size() < 5; b++) tick();
        sticky    = '0;
        req_valid = '0;
        for (int b = 0; b < 400 && (rsp_q.size() < grant_q.size() || rsp_valid || cs_start || cs_busy); b++) tick();
        chk("rr_grant_count", grant_q.size(), 5);
        chk("rr_rsp_count", rsp_q.size(), grant_q.size());
        if (grant_q.size() >= 5) begin
            chk("rr_g0", grant_q[0], 1);
            chk("rr_g1", grant_q[1], 3);
            chk("rr_g2", grant_q[2], 1);
            chk("rr_g3", grant_q[3], 3);
            chk("rr_g4", grant_q[4], 0);
        end
        for (int i = 0; i < rsp_q.size() && i < grant_q.size(); i++) begin
            chk($sformatf("rr_rsp_id[%0d]", i), rsp_q[i].id, grant_q[i]);
            chk($sformatf("rr_rsp_y[%0d]", i), rsp_q[i].y, (grant_q[i] == 1) ? 1 : (grant_q[i] == 0) ? 3 : 0);
        end

        // Response backpressure: outputs hold and no new grant while waiting.
        do_reset();
        rsp_ready        = 1'b0;
        req_x[23:16]     = 8'd64;
        req_valid[2]     = 1'b1;
        for (int b = 0; b < 200 && !rsp_valid; b++) tick();
        chk("bp_reach_resp", int'(rsp_valid), 1);
        req_x[7:0]   = 8'd8;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", int'(rsp_valid), 1);
            chk("bp_id", int'(rsp_id), 2);
            chk("bp_y", int'(rsp_y), 4);
            chk("bp_ready", int'(req_ready), 0);
        end
        chk("bp_grants_held", grant_q.size(), 1);
        rsp_ready = 1'b1;
        run_until_rsp(2, 200);
        if (rsp_q.size() >= 2) begin
            chk("bp_rsp0_id", rsp_q[0].id, 2);
            chk("bp_rsp0_y", rsp_q[0].y, 4);
            chk("bp_rsp1_id", rsp_q[1].id, 0);
            chk("bp_rsp1_y", rsp_q[1].y, 2);
        end

        // Hung unit: watchdog trips, resets the unit for two cycles, reports an error.
        do_reset();
        stuck        = 1'b1;
        req_x[7:0]   = 8'd27;
        req_valid[0] = 1'b1;
        run_until_rsp(1, TIMEOUT + 40);
        if (rsp_q.size() >= 1) begin
            chk("wd_err", rsp_q[0].err, 1);
            chk("wd_y", rsp_q[0].y, 0);
            chk("wd_id", rsp_q[0].id, 0);
        end
        chk("wd_rst_cycles", rst_hi_n, 2);
        chk("wd_trip_latency", rst_rise_cyc - start_rise_cyc, TIMEOUT);
        stuck = 1'b0;
        txn(0, 8'd64, 8'd4);

        // Reset while the unit is computing aborts without a response.
        do_reset();
        req_x[7:0]   = 8'd27;
        req_valid[0] = 1'b1;
        for (int b = 0; b < 50 && !(cs_busy && !cs_start); b++) tick();
        chk("mid_reach_wait", int'(cs_busy && !cs_start), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rsp_valid", int'(rsp_valid), 0);
        chk("mid_cs_start", int'(cs_start), 0);
        chk("mid_cs_x", int'(cs_x), 0);
        chk("mid_rsp_id", int'(rsp_id), 0);
        chk("mid_rsp_y", int'(rsp_y), 0);
        chk("mid_cs_rst", int'(cs_rst), 1);
        rst_n = 1'b1;
        chk("mid_rst_hold", int'(cs_rst), 1);
        tick();
        chk("mid_rst_drop", int'(cs_rst), 0);
        for (int i = 0; i < 10; i++) tick();
        chk("mid_no_rsp", rsp_q.size(), 0);
        txn(0, 8'd125, 8'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
